// File: rtl/aes_pkg.sv
// Shared AES-128 constants, S-box table, GF(2^8) xtime helper and key-expander FSM states.
package aes_pkg;

   localparam int          NR        = 10;
   localparam logic [7:0]  RCON_INIT = 8'h01;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      WAIT = 2'd2
   } state_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single-byte AES S-box lookup, purely combinational.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] in_byte,
   output logic [7:0] sub_byte
);

   assign sub_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key expander: streams round keys 0..10 one per handshake under rk_valid/rk_ready.
// Optional macro KEY_STORE_EN keeps every emitted round key readable through rd_idx/rd_key.
module aes_key_expand
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   input  logic         rk_ready,
   input  logic [3:0]   rd_idx,
   output logic [127:0] round_key,
   output logic [3:0]   round_num,
   output logic         rk_valid,
   output logic         busy,
   output logic         done,
   output logic [127:0] rd_key
);

   localparam logic [3:0] LAST = 4'(NR);

   state_t         state, state_nxt;
   logic [127:0]   key_nxt;
   logic [3:0]     num_nxt;
   logic           vld_nxt;
   logic [7:0]     rcon, rcon_nxt;

   logic [31:0]    w0, w1, w2, w3, rot, sub;
   logic [31:0]    n0, n1, n2, n3;
   logic           hs;

   // Round function: next key derived from the key currently on the output
   assign {w0, w1, w2, w3} = round_key;
   assign rot = {w3[23:0], w3[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_subword
      aes_sbox u_sbox (
         .in_byte  (rot[8*i +: 8]),
         .sub_byte (sub[8*i +: 8])
      );
   end

   assign n0 = w0 ^ sub ^ {rcon, 24'h000000};
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;

   assign hs   = (state == EMIT) && rk_valid && rk_ready;
   assign done = hs && (round_num == LAST);
   assign busy = (state != IDLE);

   always_comb begin
      state_nxt = state;
      key_nxt   = round_key;
      num_nxt   = round_num;
      vld_nxt   = rk_valid;
      rcon_nxt  = rcon;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = EMIT;
               key_nxt   = key_in;
               num_nxt   = 4'd0;
               vld_nxt   = 1'b1;
               rcon_nxt  = RCON_INIT;
            end
         end
         EMIT: begin
            if (hs) begin
               if (round_num == LAST) begin
                  state_nxt = IDLE;
                  vld_nxt   = 1'b0;
               end else begin
                  key_nxt  = {n0, n1, n2, n3};
                  num_nxt  = round_num + 4'd1;
                  rcon_nxt = xtime(rcon);
               end
            end
         end
         // WAIT is reserved and, like any undefined encoding, falls back to a clean IDLE
         default: begin
            state_nxt = IDLE;
            key_nxt   = '0;
            num_nxt   = 4'd0;
            vld_nxt   = 1'b0;
            rcon_nxt  = RCON_INIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         round_key <= '0;
         round_num <= 4'd0;
         rk_valid  <= 1'b0;
         rcon      <= RCON_INIT;
      end else begin
         state     <= state_nxt;
         round_key <= key_nxt;
         round_num <= num_nxt;
         rk_valid  <= vld_nxt;
         rcon      <= rcon_nxt;
      end
   end

`ifdef KEY_STORE_EN
   logic [127:0] store [0:NR];

   // Rewriting the same slot while stalled is harmless; the value is stable
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i <= NR; i++) store[i] <= '0;
      end else if ((state == EMIT) && rk_valid) begin
         store[round_num] <= round_key;
      end
   end

   assign rd_key = (rd_idx <= LAST) ? store[rd_idx] : '0;
`else
   logic unused_rd_idx;
   assign unused_rd_idx = ^rd_idx;
   assign rd_key        = '0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand using FIPS-197 and all-zero key expansion tables.
module tb_aes_key_expand;

   logic         clk = 1'b0;
   logic         rst, start, rk_ready;
   logic [127:0] key_in;
   logic [3:0]   rd_idx;
   logic [127:0] round_key, rd_key;
   logic [3:0]   round_num;
   logic         rk_valid, busy, done;

   int checks = 0;
   int errors = 0;
   int hs_cnt = 0;
   int done_cnt = 0;

   typedef struct {
      logic [127:0] key;
      logic [3:0]   num;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   localparam logic [127:0] FIPS_RK [11] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
   };

   localparam logic [127:0] ZERO_RK [11] = '{
      128'h00000000000000000000000000000000,
      128'h62636363626363636263636362636363,
      128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
      128'h90973450696ccffaf2f457330b0fac99,
      128'hee06da7b876a1581759e42b27e91ee2b,
      128'h7f2e2b88f8443e098dda7cbbf34b9290,
      128'hec614b851425758c99ff09376ab49ba7,
      128'h217517873550620bacaf6b3cc61bf09b,
      128'h0ef903333ba9613897060a04511dfa9f,
      128'hb1d4d8e28a7db9da1d7bb3de4c664941,
      128'hb4ef5bcb3e92e21123e951cf6f8f188e
   };

   aes_key_expand dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .key_in    (key_in),
      .rk_ready  (rk_ready),
      .rd_idx    (rd_idx),
      .round_key (round_key),
      .round_num (round_num),
      .rk_valid  (rk_valid),
      .busy      (busy),
      .done      (done),
      .rd_key    (rd_key)
   );

   always #5 clk = ~clk;

   // Scoreboard: every accepted round key is popped and checked, with done expected only on round 10
   always @(negedge clk) begin
      if (!rst && rk_valid && rk_ready) begin
         hs_cnt++;
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_handshake round_num=%0d round_key=%h", round_num, round_key);
         end else begin
            mon_e = sb_q.pop_front();
            if (round_key !== mon_e.key || round_num !== mon_e.num) begin
               errors++;
               $display("FAIL round_key got num=%0d key=%h expected num=%0d key=%h",
                        round_num, round_key, mon_e.num, mon_e.key);
            end
            checks++;
            if (done !== (mon_e.num == 4'd10)) begin
               errors++;
               $display("FAIL done_pulse round=%0d got=%b expected=%b", mon_e.num, done, (mon_e.num == 4'd10));
            end
         end
      end
      if (done === 1'b1) done_cnt++;
   end

   task automatic push_keys(input bit zero_key);
      exp_t e;
      for (int i = 0; i < 11; i++) begin
         e.key = zero_key ? ZERO_RK[i] : FIPS_RK[i];
         e.num = 4'(i);
         sb_q.push_back(e);
      end
   endtask

   task automatic pulse_start(input logic [127:0] k);
      @(posedge clk); #1;
      key_in = k;
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
   endtask

   task automatic wait_round(input logic [3:0] k, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (rk_valid && round_num == k) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_drain(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk); #1;
         if (sb_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b1; key_in = FIPS_KEY; rk_ready = 1'b1; rd_idx = 4'd1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (round_key !== '0 || round_num !== 4'd0 || rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_state key=%h num=%0d vld=%b busy=%b done=%b expected all zero",
                  round_key, round_num, rk_valid, busy, done);
      end
      checks++;
      if (rd_key !== '0) begin
         errors++;
         $display("FAIL reset_rd_key got=%h expected=0", rd_key);
      end
      start = 1'b0;
      rst   = 1'b0;
   endtask

   task automatic test_fips;
      bit ok;
      int d0 = done_cnt;
      push_keys(1'b0);
      pulse_start(FIPS_KEY);
      checks++;
      if (rk_valid !== 1'b1 || round_num !== 4'd0 || round_key !== FIPS_KEY || busy !== 1'b1) begin
         errors++;
         $display("FAIL first_latency vld=%b num=%0d key=%h busy=%b expected vld=1 num=0 key=%h busy=1",
                  rk_valid, round_num, round_key, busy, FIPS_KEY);
      end
      wait_drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL fips_drain left=%0d expected=0", sb_q.size());
      end
      @(posedge clk); #1;
      checks++;
      if (rk_valid !== 1'b0 || busy !== 1'b0 || done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL fips_end vld=%b busy=%b dones=%0d expected vld=0 busy=0 dones=1",
                  rk_valid, busy, done_cnt - d0);
      end
`ifdef KEY_STORE_EN
      rd_idx = 4'd1; #1;
      checks++;
      if (rd_key !== FIPS_RK[1]) begin
         errors++;
         $display("FAIL store_rd1 got=%h expected=%h", rd_key, FIPS_RK[1]);
      end
      rd_idx = 4'd10; #1;
      checks++;
      if (rd_key !== FIPS_RK[10]) begin
         errors++;
         $display("FAIL store_rd10 got=%h expected=%h", rd_key, FIPS_RK[10]);
      end
      rd_idx = 4'd15; #1;
      checks++;
      if (rd_key !== '0) begin
         errors++;
         $display("FAIL store_rd15 got=%h expected=0", rd_key);
      end
`else
      rd_idx = 4'd10; #1;
      checks++;
      if (rd_key !== '0) begin
         errors++;
         $display("FAIL rd_key_tied got=%h expected=0", rd_key);
      end
`endif
   endtask

   task automatic test_zero_key;
      bit ok;
      int d0 = done_cnt;
      push_keys(1'b1);
      pulse_start('0);
      wait_drain(ok);
      checks++;
      if (!ok || done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL zero_key drained=%b dones=%0d expected drained=1 dones=1", ok, done_cnt - d0);
      end
   endtask

   task automatic test_backpressure;
      bit ok;
      int d0 = done_cnt;
      int h0 = hs_cnt;
      push_keys(1'b0);
      pulse_start(FIPS_KEY);
      wait_round(4'd4, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL bp_reach_round4 got num=%0d expected=4", round_num);
      end
      rk_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (rk_valid !== 1'b1 || round_num !== 4'd4 || round_key !== FIPS_RK[4] || done !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold cycle=%0d vld=%b num=%0d key=%h expected vld=1 num=4 key=%h",
                     c, rk_valid, round_num, round_key, FIPS_RK[4]);
         end
      end
      @(posedge clk); #1;
      rk_ready = 1'b1;
      wait_drain(ok);
      checks++;
      if (!ok || hs_cnt - h0 != 11 || done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL bp_totals drained=%b handshakes=%0d dones=%0d expected 1/11/1",
                  ok, hs_cnt - h0, done_cnt - d0);
      end
   endtask

   task automatic test_start_ignored;
      bit ok;
      int d0 = done_cnt;
      push_keys(1'b0);
      pulse_start(FIPS_KEY);
      wait_round(4'd5, ok);
      start  = 1'b1;
      key_in = 128'h00112233445566778899aabbccddeeff;
      @(posedge clk); #1;
      start  = 1'b0;
      checks++;
      if (!ok || busy !== 1'b1 || round_num !== 4'd6 || round_key !== FIPS_RK[6]) begin
         errors++;
         $display("FAIL start_while_busy num=%0d key=%h expected num=6 key=%h", round_num, round_key, FIPS_RK[6]);
      end
      wait_drain(ok);
      checks++;
      if (!ok || done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL start_busy_done drained=%b dones=%0d expected 1/1", ok, done_cnt - d0);
      end
   endtask

   task automatic test_back_to_back;
      bit ok;
      int d0 = done_cnt;
      push_keys(1'b0);
      pulse_start(FIPS_KEY);
      wait_round(4'd10, ok);
      push_keys(1'b1);
      key_in = '0;
      start  = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (!ok || rk_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL start_on_done vld=%b busy=%b expected vld=0 busy=0", rk_valid, busy);
      end
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (rk_valid !== 1'b1 || round_num !== 4'd0 || round_key !== '0) begin
         errors++;
         $display("FAIL start_after_done vld=%b num=%0d key=%h expected vld=1 num=0 key=0",
                  rk_valid, round_num, round_key);
      end
      wait_drain(ok);
      checks++;
      if (!ok || done_cnt - d0 != 2) begin
         errors++;
         $display("FAIL b2b_totals drained=%b dones=%0d expected 1/2", ok, done_cnt - d0);
      end
   endtask

   task automatic test_reset_mid;
      bit ok;
      int d0 = done_cnt;
      push_keys(1'b0);
      pulse_start(FIPS_KEY);
      wait_round(4'd6, ok);
      rst   = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      rst   = 1'b0;
      start = 1'b0;
      checks++;
      if (!ok || round_key !== '0 || round_num !== 4'd0 || rk_valid !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0 || done_cnt != d0) begin
         errors++;
         $display("FAIL reset_mid key=%h num=%0d vld=%b busy=%b dones=%0d expected all zero",
                  round_key, round_num, rk_valid, busy, done_cnt - d0);
      end
      sb_q.delete();
      push_keys(1'b0);
      pulse_start(FIPS_KEY);
      wait_drain(ok);
      checks++;
      if (!ok || done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL reset_rerun drained=%b dones=%0d expected 1/1", ok, done_cnt - d0);
      end
   endtask

   initial begin
      test_reset();
      test_fips();
      test_zero_key();
      test_backpressure();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/aes_key_expand.md
AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 Parameters: none; AES-128 only, Nr = 10 fixed in the package.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request expansion of key_in; honoured only in IDLE.
REQ-005 key_in  input  128  cipher key, byte 0 in bits [127:120]; sampled on the accepted start cycle only.
REQ-006 rk_ready  input  1  consumer (AddRoundKey stage) accepts round_key this cycle.
REQ-007 round_key  output  128  current round key, same byte order as key_in.
REQ-008 round_num  output  4  index of round_key, 0..10.
REQ-009 rk_valid  output  1  round_key/round_num valid.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 done  output  1  one-cycle pulse on the handshake of round 10.
REQ-012 rd_idx  input  4  stored-key read index (used only with KEY_STORE_EN).
REQ-013 rd_key  output  128  stored round key rd_idx, combinational read.

Function
REQ-014 FSM states: IDLE, EMIT, WAIT; state held in a registered enum.
REQ-015 IDLE, start=1: latch key_in into round_key, round_num=0, rk_valid=1, next EMIT.
REQ-016 EMIT, rk_valid & rk_ready, round_num<10: next cycle round_key = next key, round_num+1, rk_valid stays 1.
REQ-017 EMIT, rk_ready=0: round_key, round_num, rk_valid held unchanged (no data loss under backpressure).
REQ-018 Round 10 handshake: done=1 that cycle (combinational from state, round_num=10 and rk_ready); next cycle rk_valid=0, state IDLE.
REQ-019 Next-key rule per FIPS-197: w0' = w0 ^ SubWord(RotWord(w3)) ^ {Rcon,00,00,00}; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
REQ-020 Rcon held in an 8-bit register: 01 at round 0, xtime each advance (x2, XOR 1b on carry) -> 01,02,04,08,10,20,40,80,1b,36.
REQ-021 One round key per cycle with rk_ready tied high: 11 consecutive rk_valid cycles, start-to-first-valid latency 1 cycle.
REQ-022 start while busy ignored; key_in change while busy has no effect.
REQ-023 start in the cycle done pulses is ignored; a new start is accepted the following cycle (IDLE).
REQ-024 WAIT state reserved; unreachable, any illegal state recovers to IDLE with outputs cleared.

Reset
REQ-025 rst=1: state IDLE, round_key=0, round_num=0, rk_valid=0, busy=0, done=0, Rcon=01, key store cleared.
REQ-026 rst mid-expansion aborts immediately; no done pulse; reset dominates start in the same cycle.

Configuration
REQ-027 Macro KEY_STORE_EN defined: 11x128 register array written with each round key as it becomes valid; rd_key = store[rd_idx], rd_idx>10 returns 0.
REQ-028 KEY_STORE_EN undefined: no array synthesized; rd_key tied to 0, rd_idx ignored; all other behaviour identical.

Structure
REQ-029 Package aes_pkg holds: SBOX 256x8 constant, NR=10, RCON_INIT=8'h01, xtime function, FSM state typedef.
REQ-030 Sub-module aes_sbox (8-bit combinational lookup from aes_pkg); four instances form SubWord.
REQ-031 No other sub-modules; target 150-300 RTL lines.

Verification
REQ-032 key_in=2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> round 1 a0fafe1788542cb123a339392a6c7605, round 10 d014f9a8c9ee2589e13f0cc8b6630ca6, done with round 10.
REQ-033 key_in=0 -> round 1 62636363626363636263636362636363, round 10 b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-034 FIPS key, rk_ready low 3 cycles at round 4 -> round_key/round_num=4 held stable, sequence resumes unchanged, total 11 handshakes.
REQ-035 start pulsed with different key_in at round 5 -> ignored, round 10 key still d014f9a8...; single done.
REQ-036 rst asserted at round 6 -> next cycle all outputs 0, IDLE, no done; fresh start reproduces REQ-032 values.
REQ-037 KEY_STORE_EN build, after REQ-032 run: rd_idx=1 -> a0fafe17...; rd_idx=10 -> d014f9a8...; rd_idx=15 -> 0.
